// File: rtl/pc_gen_btb_pkg.sv
// Shared next-PC op encoding, BTB entry field widths and 2-bit counter helpers
// for the fetch-stage PC generator.
package pc_gen_btb_pkg;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JALR   = 2'b11
    } npc_op_e;

    localparam int VALID_W   = 1;
    localparam int IS_JUMP_W = 1;
    localparam int CNT_WIDTH = 2;

    localparam logic [1:0] CNT_MIN = 2'b00;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    function automatic logic [1:0] cnt_inc(input logic [1:0] cnt);
        return (cnt == CNT_ST) ? cnt : cnt + 2'b01;
    endfunction

    function automatic logic [1:0] cnt_dec(input logic [1:0] cnt);
        return (cnt == CNT_MIN) ? cnt : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/pc_gen_btb_if.sv
// Fetch/execute-side bus of the PC generator: fetch PC and prediction out,
// resolved EX instruction in, redirect back to the pipeline.
interface pc_gen_btb_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [1:0]      ex_npcop;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_c;
    logic            ex_br_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output stall, ex_valid, ex_pc, ex_npcop, ex_imm, ex_c, ex_br_taken, ex_pred_target,
        input  pc, pred_taken, pred_target, redirect, redirect_pc
    );

    modport slave (
        input  stall, ex_valid, ex_pc, ex_npcop, ex_imm, ex_c, ex_br_taken, ex_pred_target,
        output pc, pred_taken, pred_target, redirect, redirect_pc
    );
endinterface

// File: rtl/pc_gen_btb_btb_dm.sv
// Direct-mapped BTB storage: two combinational read ports (fetch lookup and
// EX-side update lookup) and one synchronous write port; rst clears valids.
module btb_dm
    import pc_gen_btb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = CNT_WIDTH,
    localparam int IDX_W  = $clog2(ENTRIES),
    localparam int TAG_W  = XLEN - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [XLEN-2:0]  rd_target,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             rd_is_jump,
    input  logic [IDX_W-1:0] up_idx,
    output logic             up_valid,
    output logic [TAG_W-1:0] up_tag,
    output logic [XLEN-2:0]  up_target,
    output logic [CNT_W-1:0] up_cnt,
    output logic             up_is_jump,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [XLEN-2:0]  wr_target,
    input  logic [CNT_W-1:0] wr_cnt,
    input  logic             wr_is_jump
);

    logic [ENTRIES-1:0] valid_q, valid_d, is_jump_q, is_jump_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-2:0]    target_q [ENTRIES];
    logic [XLEN-2:0]    target_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [CNT_W-1:0]   cnt_d    [ENTRIES];

    // Reads see pre-write contents: no bypass from the write port.
    assign rd_valid   = valid_q[rd_idx];
    assign rd_tag     = tag_q[rd_idx];
    assign rd_target  = target_q[rd_idx];
    assign rd_cnt     = cnt_q[rd_idx];
    assign rd_is_jump = is_jump_q[rd_idx];
    assign up_valid   = valid_q[up_idx];
    assign up_tag     = tag_q[up_idx];
    assign up_target  = target_q[up_idx];
    assign up_cnt     = cnt_q[up_idx];
    assign up_is_jump = is_jump_q[up_idx];

    // Next-state of the entry array for a single-entry write.
    always_comb begin
        valid_d   = valid_q;
        is_jump_d = is_jump_q;
        tag_d     = tag_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        if (wr_en) begin
            valid_d[wr_idx]   = 1'b1;
            is_jump_d[wr_idx] = wr_is_jump;
            tag_d[wr_idx]     = wr_tag;
            target_d[wr_idx]  = wr_target;
            cnt_d[wr_idx]     = wr_cnt;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry array; only the valid bits are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        is_jump_q <= is_jump_d;
        tag_q     <= tag_d;
        target_q  <= target_d;
        cnt_q     <= cnt_d;
    end

endmodule

// File: rtl/pc_gen_btb.sv
// Next-PC generator: registered fetch PC, BTB-driven prediction, EX-stage
// resolution with redirect on mispredict, and BTB training.
module pc_gen_btb
    import pc_gen_btb_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}},
    parameter int              CNT_W       = CNT_WIDTH
) (
    input logic         clk,
    input logic         rst,
    pc_gen_btb_if.slave bus
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] LSB_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag, f_rd_tag, e_rd_tag;
    logic             f_valid, e_valid, f_is_jump, e_is_jump, f_hit, e_hit;
    logic [XLEN-2:0]  f_target, e_target;
    logic [CNT_W-1:0] f_cnt, e_cnt;
    logic             pred_taken, redirect;
    logic [XLEN-1:0]  pred_target, act_npc, imm_even;
    logic             wr_en, wr_is_jump;
    logic [XLEN-2:0]  wr_target;
    logic [CNT_W-1:0] wr_cnt;

    assign f_idx    = pc_q[IDX_W+1:2];
    assign f_tag    = pc_q[XLEN-1:IDX_W+2];
    assign e_idx    = bus.ex_pc[IDX_W+1:2];
    assign e_tag    = bus.ex_pc[XLEN-1:IDX_W+2];
    assign imm_even = bus.ex_imm & LSB_MASK;

    btb_dm #(.XLEN(XLEN), .ENTRIES(BTB_ENTRIES), .CNT_W(CNT_W)) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (f_idx),
        .rd_valid  (f_valid),
        .rd_tag    (f_rd_tag),
        .rd_target (f_target),
        .rd_cnt    (f_cnt),
        .rd_is_jump(f_is_jump),
        .up_idx    (e_idx),
        .up_valid  (e_valid),
        .up_tag    (e_rd_tag),
        .up_target (e_target),
        .up_cnt    (e_cnt),
        .up_is_jump(e_is_jump),
        .wr_en     (wr_en),
        .wr_idx    (e_idx),
        .wr_tag    (e_tag),
        .wr_target (wr_target),
        .wr_cnt    (wr_cnt),
        .wr_is_jump(wr_is_jump)
    );

    // Fetch-side prediction for the current PC.
    always_comb begin
        f_hit       = f_valid && (f_rd_tag == f_tag);
        pred_taken  = f_hit && (f_is_jump || f_cnt[1]);
        pred_target = pred_taken ? {f_target, 1'b0} : pc_q + PC_STEP;
    end

    // Resolved next PC of the EX instruction and mispredict detection.
    always_comb begin
        case (npc_op_e'(bus.ex_npcop))
            NPC_PLUS4:  act_npc = bus.ex_pc + PC_STEP;
            NPC_BRANCH: act_npc = bus.ex_br_taken ? bus.ex_pc + imm_even : bus.ex_pc + PC_STEP;
            NPC_JUMP:   act_npc = bus.ex_pc + imm_even;
            NPC_JALR:   act_npc = bus.ex_c & LSB_MASK;
            default:    act_npc = bus.ex_pc + PC_STEP;
        endcase
        redirect = bus.ex_valid && (act_npc != bus.ex_pred_target);
    end

    // BTB training from the resolved EX instruction.
    always_comb begin
        e_hit      = e_valid && (e_rd_tag == e_tag);
        wr_en      = 1'b0;
        wr_target  = act_npc[XLEN-1:1];
        wr_cnt     = CNT_ST;
        wr_is_jump = 1'b0;
        if (bus.ex_valid && !rst) begin
            case (npc_op_e'(bus.ex_npcop))
                NPC_JUMP, NPC_JALR: begin
                    wr_en      = 1'b1;
                    wr_is_jump = 1'b1;
                    wr_cnt     = CNT_ST;
                end
                NPC_BRANCH: begin
                    if (e_hit && bus.ex_br_taken) begin
                        wr_en  = 1'b1;
                        wr_cnt = cnt_inc(e_cnt);
                    end else if (e_hit) begin
                        // Not-taken hit only weakens the counter; target kept.
                        wr_en      = 1'b1;
                        wr_cnt     = cnt_dec(e_cnt);
                        wr_target  = e_target;
                        wr_is_jump = e_is_jump;
                    end else if (bus.ex_br_taken) begin
                        wr_en  = 1'b1;
                        wr_cnt = CNT_WT;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                default: wr_en = 1'b0;
            endcase
        end else begin
            wr_en = 1'b0;
        end
    end

    // Fetch PC selection: redirect beats stall.
    always_comb begin
        if (redirect) begin
            pc_d = act_npc;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pred_target;
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;
    assign bus.redirect    = redirect;
    assign bus.redirect_pc = act_npc;

endmodule

// File: doc/pc_gen_btb.md
Name: pc_gen_btb

Overview:
- Parametrised next-PC generator with a registered fetch PC and a direct-mapped branch target buffer (BTB) that uses 2-bit saturating counters.
- Predicts the next fetch address in the fetch stage.
- Resolves the actual next PC from the execute stage using the shared NPC_* op encoding, and redirects/flushes on mispredict.
- Replaces the combinational next-PC logic in the pipelined core.

Parameters:
- XLEN, 32, address/data width.
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2. IDX_W = log2(BTB_ENTRIES).
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- CNT_W, 2, counter width; fixed at 2, parameter exists for the package.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold fetch PC (hazard unit).
- pc  out  XLEN  current fetch PC, registered.
- pred_taken  out  1  fetch-stage prediction for pc.
- pred_target  out  XLEN  predicted next PC for pc; pc+4 when not taken.
- ex_valid  in  1  EX-stage instruction valid.
- ex_pc  in  XLEN  PC of EX instruction.
- ex_npcop  in  2  NPC_PLUS4/NPC_BRANCH/NPC_JUMP/NPC_JALR.
- ex_imm  in  XLEN  sign-extended immediate (B or J format).
- ex_c  in  XLEN  ALU result; JALR target before LSB clear.
- ex_br_taken  in  1  branch condition result.
- ex_pred_target  in  XLEN  pred_target carried down the pipe with the instruction.
- redirect  out  1  mispredict; combinational.
- redirect_pc  out  XLEN  correct next PC; combinational.

Behaviour:
- **Reset** (rst=1 at edge): pc<=RESET_PC; all BTB valid bits cleared. Targets, tags and counters are don't-care. Reset dominates every other input, including a mid-operation redirect.
- **BTB index/tag:** idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
  - Entry fields: valid, tag, target[XLEN-1:1], cnt[1:0], is_jump.
- **Lookup** (combinational on pc): hit = valid && tag match.
  - pred_taken = hit && (is_jump || cnt[1]).
  - pred_target = pred_taken ? target : pc+4.
- **Actual next PC** (act_npc, from ex_*):
  - PLUS4: ex_pc+4.
  - BRANCH: ex_br_taken ? ex_pc+ex_imm : ex_pc+4.
  - JUMP: ex_pc+ex_imm.
  - JALR: ex_c & ~1.
  - Adds wrap modulo 2^XLEN. ex_imm[0] is forced to 0.
- **Redirect:** redirect = ex_valid && (act_npc != ex_pred_target); redirect_pc = act_npc.
  - The pipeline flushes IF/ID on redirect.
- **PC update priority** (per edge): rst > redirect (pc<=redirect_pc) > stall (hold) > pc<=pred_target.
  - Redirect overrides stall.
- **BTB update** at edge, when ex_valid && !rst; the entry is at idx/tag of ex_pc.
  - JUMP/JALR: write valid=1, tag, target=act_npc, is_jump=1, cnt=2'b11.
  - BRANCH, entry hits:
    - taken: cnt saturating +1, target<=act_npc, is_jump=0.
    - not taken: cnt saturating −1 (floor 0); entry stays valid.
  - BRANCH, miss and taken: allocate (overwrite) with cnt=2'b10, is_jump=0.
  - BRANCH, miss and not taken: no write.
  - PLUS4: no write.
- **Simultaneous lookup/update of the same index:** the lookup uses the pre-update contents; no bypass. Update is applied regardless of stall.
- **Aliasing:** a different tag at the same idx is a miss; allocation replaces the entry.
- Latency: the prediction affects the next-cycle pc. Mispredict penalty is fixed by pipeline depth; the block adds no cycles.

Decomposition:
- Shared package/include (ctrl_encode_def): NPC_PLUS4=2'b00, NPC_BRANCH=2'b01, NPC_JUMP=2'b10, NPC_JALR=2'b11, BTB entry field widths, and counter constants CNT_WT=2'b10 and CNT_ST=2'b11.
- One sub-module, btb_dm: storage array, combinational lookup port, synchronous write port, synchronous valid clear on rst.
- Top keeps the PC register, act_npc/redirect logic and counter update.

Test Plan:
- **Reset and sequential fetch:** rst=1 for 2 cycles, then 0 → pc=0x0, then 0x4, 0x8, 0xC; pred_taken=0 throughout.
- **Cold taken branch:** ex_valid=1, ex_pc=0x10, ex_npcop=BRANCH, ex_imm=0x20, ex_br_taken=1, ex_pred_target=0x14 → redirect=1, redirect_pc=0x30, next pc=0x30. A later fetch of 0x10 gives pred_taken=1, pred_target=0x30 (cnt=2).
- **Predicted branch not taken:** same branch, ex_br_taken=0, ex_pred_target=0x30 → redirect=1, pc<=0x14, cnt becomes 1. A subsequent fetch of 0x10 gives pred_taken=0, pred_target=0x14. Repeating not-taken saturates cnt at 0 with the entry still valid.
- **JALR:** ex_pc=0x40, ex_npcop=JALR, ex_c=0x1235, ex_pred_target=0x44 → redirect_pc=0x1234. A later fetch of 0x40 predicts 0x1234. A correct prediction gives redirect=0.
- **Stall/redirect priority:**
  - stall=1 alone → pc holds for 3 cycles.
  - stall=1 plus redirect to 0x80 → pc=0x80 next cycle.
  - rst=1 plus redirect → pc=RESET_PC and the BTB is empty.
- **Aliasing:** entry allocated at 0x10 (idx 4); fetch 0x50 (idx 4, different tag) → pred_taken=0. A taken branch at 0x50 replaces the entry, and 0x10 then misses.
